// File: rtl/rgb_mixer_pkg.sv
// Shared constants and types for the RGB mixer: colour depth, PWM prescale
// default and channel indexing used when instantiating the per-colour blocks.
package rgb_mixer_pkg;

    localparam int CHAN_WIDTH       = 8;
    localparam int DEFAULT_PRESCALE = 1;
    localparam int NUM_CHANS        = 3;

    typedef enum logic [1:0] {
        CHAN_R = 2'd0,
        CHAN_G = 2'd1,
        CHAN_B = 2'd2
    } chan_idx_e;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk down to one PWM count tick every PRESCALE clocks; held at zero
// while idle so every enabled run starts on a fresh count boundary.
module pwm_prescaler
    import rgb_mixer_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick,
    output logic pre_zero
);

    localparam int            PW       = cnt_bits(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_cnt;

    assign tick     = (pre_cnt == PRE_LAST);
    assign pre_zero = (pre_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/pwm_channel.sv
// One LED colour channel: turns an encoder intensity into a glitch-free PWM
// drive with a period-start strobe for debug and cross-channel alignment.
module pwm_channel
    import rgb_mixer_pkg::*;
#(
    parameter int WIDTH    = CHAN_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter bit INVERT   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out,
    output logic             period_start
);

    logic             tick;
    logic             pre_zero;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_q;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .tick     (tick),
        .pre_zero (pre_zero)
    );

    // duty_q only moves at the period wrap while running, so a mid-period
    // duty input change can never truncate or extend the pulse in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            duty_q       <= '0;
            pwm_out      <= INVERT;
            period_start <= 1'b0;
        end else if (!enable) begin
            cnt          <= '0;
            duty_q       <= duty;
            pwm_out      <= INVERT;
            period_start <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= cnt + WIDTH'(1);
                if (cnt == '1) begin
                    duty_q <= duty;
                end
            end
            pwm_out      <= (cnt < duty_q) ^ INVERT;
            period_start <= (cnt == '0) && pre_zero;
        end
    end

endmodule
